// File: rtl/sat_add_pkg.sv
// Shared types and defaults for the round-robin saturating-adder arbiter.
package sat_add_pkg;

    typedef enum logic {EMPTY, FULL} state_e;

    localparam int unsigned DefNReq = 4;
    localparam int unsigned DefW    = 4;

    // Requester index width, never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n_req);
        return (n_req <= 2) ? 1 : $clog2(n_req);
    endfunction

endpackage

// File: rtl/sat_add_core.sv
// Combinational W-bit two's-complement adder that clamps on signed overflow.
module sat_add_core #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         pos_sat,
    output logic         neg_sat
);

    logic [W-1:0] raw;

    always_comb begin
        raw     = a + b;
        // Overflow is only possible when both operands share a sign the result lacks.
        pos_sat = ~a[W-1] & ~b[W-1] & raw[W-1];
        neg_sat = a[W-1] & b[W-1] & ~raw[W-1];
        if (pos_sat) begin
            sum = {1'b0, {(W-1){1'b1}}};
        end else if (neg_sat) begin
            sum = {1'b1, {(W-1){1'b0}}};
        end else begin
            sum = raw;
        end
    end

endmodule

// File: rtl/sat_add_arbiter.sv
// Round-robin arbiter sharing one saturating adder among N_REQ requesters,
// with a one-entry tagged result register on a valid/ready output.
module sat_add_arbiter
    import sat_add_pkg::*;
#(
    parameter int unsigned N_REQ = DefNReq,
    parameter int unsigned W     = DefW
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  logic [N_REQ*W-1:0]             req_a,
    input  logic [N_REQ*W-1:0]             req_b,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [W-1:0]                   res_sum,
    output logic [id_width(N_REQ)-1:0]     res_id,
    output logic [1:0]                     res_sat
);

    localparam int unsigned IdW  = id_width(N_REQ);
    localparam int unsigned IdW1 = IdW + 1;

    state_e           state_q;
    logic [IdW-1:0]   ptr_q, ptr_d;
    logic [W-1:0]     sum_q;
    logic [IdW-1:0]   id_q;
    logic [1:0]       sat_q;

    logic [N_REQ-1:0] rot;
    logic [IdW-1:0]   offset;
    logic [IdW1-1:0]  sum_idx;
    logic [IdW-1:0]   win_id;
    logic [N_REQ-1:0] grant;
    logic             can_accept;
    logic             xfer;

    logic [W-1:0]     op_a, op_b, core_sum;
    logic             core_pos, core_neg;

    // Rotate so that ptr lands on bit 0, priority-encode, then rotate the index back.
    always_comb begin
        rot    = N_REQ'({req_valid, req_valid} >> ptr_q);
        offset = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                offset = IdW'(k);
            end
        end
        sum_idx = {1'b0, ptr_q} + {1'b0, offset};
        if (sum_idx >= IdW1'(N_REQ)) begin
            sum_idx = sum_idx - IdW1'(N_REQ);
        end
        win_id = sum_idx[IdW-1:0];
        grant  = '0;
        if (|req_valid) begin
            grant[win_id] = 1'b1;
        end
        ptr_d = (win_id == IdW'(N_REQ - 1)) ? '0 : win_id + 1'b1;
    end

    assign can_accept = (state_q == EMPTY) | res_ready;
    assign req_ready  = grant & {N_REQ{can_accept & ~rst}};
    assign xfer       = |req_ready;

    assign op_a = req_a[int'(win_id) * W +: W];
    assign op_b = req_b[int'(win_id) * W +: W];

    sat_add_core #(
        .W (W)
    ) u_core (
        .a       (op_a),
        .b       (op_b),
        .sum     (core_sum),
        .pos_sat (core_pos),
        .neg_sat (core_neg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            sum_q   <= '0;
            id_q    <= '0;
            sat_q   <= '0;
        end else if (xfer) begin
            state_q <= FULL;
            ptr_q   <= ptr_d;
            sum_q   <= core_sum;
            id_q    <= win_id;
            sat_q   <= {core_pos, core_neg};
        end else if (state_q == FULL && res_ready) begin
            state_q <= EMPTY;
        end
    end

    assign res_valid = (state_q == FULL);
    assign res_sum   = sum_q;
    assign res_id    = id_q;
    assign res_sat   = sat_q;

endmodule

// File: tb/tb_sat_add_arbiter.sv
// Randomised self-checking bench for sat_add_arbiter against an integer reference model.
module tb_sat_add_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   res_sum;
    logic [1:0]     res_id;
    logic [1:0]     res_sat;

    sat_add_arbiter #(
        .N_REQ (N),
        .W     (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id),
        .res_sat   (res_sat)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_consumed = 0;
    int last_win;

    // Reference state: output register contents and round-robin pointer.
    logic         m_valid;
    logic [W-1:0] m_sum;
    logic [1:0]   m_id;
    logic [1:0]   m_sat;
    int           m_ptr;
    logic [7:0]   sb[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] s, output logic [1:0] f);
        int sa, sb_i, t;
        int maxv, minv;
        sa   = $signed(a);
        sb_i = $signed(b);
        t    = sa + sb_i;
        maxv = (1 << (W - 1)) - 1;
        minv = -(1 << (W - 1));
        if (t > maxv) begin
            s = W'(maxv);
            f = 2'b10;
        end else if (t < minv) begin
            s = W'(minv);
            f = 2'b01;
        end else begin
            s = W'(t);
            f = 2'b00;
        end
    endfunction

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_sum   = '0;
        m_id    = '0;
        m_sat   = '0;
        m_ptr   = 0;
        sb.delete();
    endtask

    // One clock: check grant, scoreboard any consumed result, advance model, check outputs.
    task automatic cycle();
        int           win;
        logic [N-1:0] exp_rdy;
        logic [W-1:0] s;
        logic [1:0]   f;
        logic [7:0]   exp_res;
        #1;
        win = -1;
        if (!m_valid || res_ready) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (req_valid[i] && win < 0) win = i;
            end
        end
        exp_rdy = '0;
        if (win >= 0) exp_rdy[win] = 1'b1;
        check_eq("req_ready", req_ready, exp_rdy);
        if (res_valid && res_ready) begin
            check_eq("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                exp_res = sb.pop_front();
                check_eq("sb_result", {res_id, res_sat, res_sum}, exp_res);
                n_consumed++;
            end
        end
        @(posedge clk);
        if (win >= 0) begin
            ref_add(req_a[win*W +: W], req_b[win*W +: W], s, f);
            m_valid = 1'b1;
            m_sum   = s;
            m_sat   = f;
            m_id    = 2'(win);
            m_ptr   = (win + 1) % N;
            sb.push_back({m_id, f, s});
        end else if (m_valid && res_ready) begin
            m_valid = 1'b0;
        end
        last_win = win;
        #1;
        check_eq("res_valid", res_valid, m_valid);
        if (m_valid) begin
            check_eq("res_sum", res_sum, m_sum);
            check_eq("res_id", res_id, m_id);
            check_eq("res_sat", res_sat, m_sat);
        end
    endtask

    task automatic drain();
        req_valid = '0;
        res_ready = 1'b1;
        cycle();
        cycle();
    endtask

    logic [W-1:0] sat_a[4]   = '{4'd7, 4'h8, 4'd7, 4'hD};
    logic [W-1:0] sat_b[4]   = '{4'd1, 4'hF, 4'h8, 4'hC};
    logic [W-1:0] sat_s[4]   = '{4'b0111, 4'b1000, 4'b1111, 4'b1001};
    logic [1:0]   sat_f[4]   = '{2'b10, 2'b01, 2'b00, 2'b00};
    int           fair_id[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        logic [W-1:0] hold_sum;
        logic [1:0]   hold_id, hold_sat;
        int           bp_ptr;
        int           base;
        logic [N-1:0] pending;

        rst       = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
        model_reset();

        // Reset state, with requests present to show req_ready stays low.
        #3;
        check_eq("rst_valid", res_valid, 0);
        check_eq("rst_sum", res_sum, 0);
        check_eq("rst_id", res_id, 0);
        check_eq("rst_sat", res_sat, 0);
        check_eq("rst_ready", req_ready, 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;

        // Single request from requester 2.
        res_ready = 1'b1;
        set_req(2, 4'd3, 4'd2);
        req_valid = 4'b0100;
        cycle();
        check_eq("single_valid", res_valid, 1);
        check_eq("single_sum", res_sum, 5);
        check_eq("single_id", res_id, 2);
        check_eq("single_sat", res_sat, 0);
        req_valid = '0;
        cycle();

        // Saturation corner cases through requester 0.
        for (int i = 0; i < 4; i++) begin
            set_req(0, sat_a[i], sat_b[i]);
            req_valid = 4'b0001;
            cycle();
            check_eq("sat_sum", res_sum, sat_s[i]);
            check_eq("sat_flags", res_sat, sat_f[i]);
            req_valid = '0;
        end

        // Backpressure while FULL with every requester waiting.
        for (int i = 0; i < N; i++) set_req(i, W'(i + 1), W'(i));
        req_valid = '1;
        res_ready = 1'b0;
        hold_sum  = res_sum;
        hold_id   = res_id;
        hold_sat  = res_sat;
        bp_ptr    = m_ptr;
        for (int c = 0; c < 3; c++) begin
            cycle();
            check_eq("bp_sum", res_sum, hold_sum);
            check_eq("bp_id", res_id, hold_id);
            check_eq("bp_sat", res_sat, hold_sat);
            check_eq("bp_noready", req_ready, 0);
        end
        res_ready = 1'b1;
        cycle();
        check_eq("bp_next", last_win, bp_ptr);
        req_valid = '0;

        // Asynchronous reset while holding a result.
        res_ready = 1'b0;
        check_eq("pre_rst_valid", res_valid, 1);
        check_eq("pre_rst_ptr", m_ptr, 2);
        #2;
        rst       = 1'b1;
        req_valid = '1;
        #1;
        check_eq("arst_valid", res_valid, 0);
        check_eq("arst_sum", res_sum, 0);
        check_eq("arst_id", res_id, 0);
        check_eq("arst_sat", res_sat, 0);
        check_eq("arst_ready", req_ready, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fairness: all requesters valid, consumer always ready.
        res_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check_eq("fair_id", res_id, fair_id[k]);
        end
        drain();

        // Every operand pair through requester 1 under random backpressure.
        base = n_consumed;
        for (int p = 0; p < 256; p++) begin
            int tries;
            set_req(1, W'(p >> 4), W'(p));
            req_valid = 4'b0010;
            tries     = 0;
            last_win  = -1;
            while (last_win != 1 && tries < 40) begin
                res_ready = 1'($urandom_range(0, 1));
                cycle();
                tries++;
            end
            check_eq("exh_grant", last_win, 1);
            req_valid = '0;
        end
        drain();
        check_eq("exh_count", n_consumed - base, 256);

        // Random traffic on all requesters, holding each offer until accepted.
        pending = '0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, W'($urandom), W'($urandom));
                    pending[i] = 1'b1;
                end
            end
            req_valid = pending;
            res_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (last_win >= 0) pending[last_win] = 1'b0;
            req_valid = pending;
        end
        drain();
        drain();
        check_eq("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so a stuck bench still reports.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
